// File: rtl/train_sequencer.sv
// ---------------------------------------------------------------------------
// train_sequencer
//   Top-level scheduler for the Q8.8 two-layer network. For each sample it
//   steps the neurons through load, forward hidden, forward output, backprop
//   output and backprop hidden, then advances the sample address and, at the
//   end of a pass, the epoch counter. Validate mode runs one forward-only pass.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         launch a run (sampled in IDLE only)
//   mode          0 = train, 1 = validate (latched at start)
//   epochs        epoch count for a train run (latched at start)
//   abort         synchronous cancel of the current run
//   ld            one-cycle sample-load strobe
//   addr          sample index being processed
//   FPH/FPO       forward-pass strobes, hidden / output layer
//   BPO/BPH       backprop strobes, output / hidden layer
//   busy          high in every state except IDLE
//   done          one-cycle pulse when a run completes
//   epoch_cnt     epochs completed in the current run
//   sample_cnt    mirror of addr
// ---------------------------------------------------------------------------
module train_sequencer #(
    parameter int NSAMP   = 4,
    parameter int AW      = 2,
    parameter int EPW     = 8,
    parameter int FPH_CYC = 2,
    parameter int FPO_CYC = 2,
    parameter int BPO_CYC = 2,
    parameter int BPH_CYC = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic [EPW-1:0] epochs,
    input  logic           abort,
    output logic           ld,
    output logic [AW-1:0]  addr,
    output logic           FPH,
    output logic           FPO,
    output logic           BPO,
    output logic           BPH,
    output logic           busy,
    output logic           done,
    output logic [EPW-1:0] epoch_cnt,
    output logic [AW-1:0]  sample_cnt
);

    localparam int MAXC01 = (FPH_CYC > FPO_CYC) ? FPH_CYC : FPO_CYC;
    localparam int MAXC23 = (BPO_CYC > BPH_CYC) ? BPO_CYC : BPH_CYC;
    localparam int MAXC   = (MAXC01 > MAXC23) ? MAXC01 : MAXC23;
    localparam int PW     = (MAXC < 2) ? 1 : $clog2(MAXC);

    localparam logic [PW-1:0] FPH_RL   = PW'(FPH_CYC - 1);
    localparam logic [PW-1:0] FPO_RL   = PW'(FPO_CYC - 1);
    localparam logic [PW-1:0] BPO_RL   = PW'(BPO_CYC - 1);
    localparam logic [PW-1:0] BPH_RL   = PW'(BPH_CYC - 1);
    localparam logic [AW-1:0] LAST_ADR = AW'(NSAMP - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, P_FPH, P_FPO, P_BPO, P_BPH, NEXT, DONE
    } state_t;

    state_t         state, state_n;
    logic [PW-1:0]  phase, phase_n;
    logic           mode_q, mode_n;
    logic [EPW-1:0] epochs_q, epochs_n;
    logic [AW-1:0]  addr_n;
    logic [EPW-1:0] epoch_n, epoch_inc;
    logic           ld_n, fph_n, fpo_n, bpo_n, bph_n, busy_n, done_n;

    assign sample_cnt = addr;
    assign epoch_inc  = epoch_cnt + 1'b1;

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        mode_n   = mode_q;
        epochs_n = epochs_q;
        addr_n   = addr;
        epoch_n  = epoch_cnt;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    mode_n   = mode;
                    epochs_n = epochs;
                    addr_n   = '0;
                    epoch_n  = '0;
                    state_n  = (!mode && epochs == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                state_n = P_FPH;
                phase_n = FPH_RL;
            end
            P_FPH: begin
                if (phase == '0) begin
                    state_n = P_FPO;
                    phase_n = FPO_RL;
                end else begin
                    phase_n = phase - 1'b1;
                end
            end
            P_FPO: begin
                if (phase == '0) begin
                    if (mode_q) begin
                        state_n = NEXT;
                    end else begin
                        state_n = P_BPO;
                        phase_n = BPO_RL;
                    end
                end else begin
                    phase_n = phase - 1'b1;
                end
            end
            P_BPO: begin
                if (phase == '0) begin
                    state_n = P_BPH;
                    phase_n = BPH_RL;
                end else begin
                    phase_n = phase - 1'b1;
                end
            end
            P_BPH: begin
                if (phase == '0) begin
                    state_n = NEXT;
                end else begin
                    phase_n = phase - 1'b1;
                end
            end
            NEXT: begin
                if (addr == LAST_ADR) begin
                    addr_n  = '0;
                    epoch_n = epoch_inc;
                    state_n = (mode_q || epoch_inc == epochs_q) ? DONE : LOAD;
                end else begin
                    addr_n  = addr + 1'b1;
                    state_n = LOAD;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort overrides every transition; counters keep their current values.
        if (abort && state != IDLE) begin
            state_n = IDLE;
            phase_n = phase;
            addr_n  = addr;
            epoch_n = epoch_cnt;
        end

        // Outputs are decoded from the next state so they register alongside it.
        ld_n   = (state_n == LOAD);
        fph_n  = (state_n == P_FPH);
        fpo_n  = (state_n == P_FPO);
        bpo_n  = (state_n == P_BPO);
        bph_n  = (state_n == P_BPH);
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            mode_q    <= 1'b0;
            epochs_q  <= '0;
            addr      <= '0;
            epoch_cnt <= '0;
            ld        <= 1'b0;
            FPH       <= 1'b0;
            FPO       <= 1'b0;
            BPO       <= 1'b0;
            BPH       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            mode_q    <= mode_n;
            epochs_q  <= epochs_n;
            addr      <= addr_n;
            epoch_cnt <= epoch_n;
            ld        <= ld_n;
            FPH       <= fph_n;
            FPO       <= fpo_n;
            BPO       <= bpo_n;
            BPH       <= bph_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_train_sequencer.sv
module tb_train_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] epochs;
    logic       abort;
    logic       ld, FPH, FPO, BPO, BPH, busy, done;
    logic [1:0] addr, sample_cnt;
    logic [7:0] epoch_cnt;

    int checks = 0;
    int passes = 0;

    train_sequencer #(
        .NSAMP(4), .AW(2), .EPW(8),
        .FPH_CYC(2), .FPO_CYC(2), .BPO_CYC(2), .BPH_CYC(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .epochs(epochs),
        .abort(abort), .ld(ld), .addr(addr), .FPH(FPH), .FPO(FPO), .BPO(BPO),
        .BPH(BPH), .busy(busy), .done(done), .epoch_cnt(epoch_cnt),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    // Bundle: {ld,FPH,FPO,BPO,BPH,busy,done, addr[1:0], sample_cnt[1:0], epoch_cnt[7:0]}
    function automatic logic [18:0] pack_out();
        return {ld, FPH, FPO, BPO, BPH, busy, done, addr, sample_cnt, epoch_cnt};
    endfunction

    function automatic logic [18:0] mk(input logic l, f1, f2, b1, b2, bz, dn,
                                       input int a, input int ep);
        logic [1:0] a2;
        logic [7:0] e8;
        a2 = 2'(a);
        e8 = 8'(ep);
        return {l, f1, f2, b1, b2, bz, dn, a2, a2, e8};
    endfunction

    // Expected outputs on cycle k of a run (k=1 is the cycle after start is sampled).
    function automatic logic [18:0] exp_out(input logic md, input int k,
                                            input int done_cyc, input int final_ep);
        int s, p;
        s = md ? 6 : 10;
        if (k < done_cyc) begin
            p = (k - 1) % s;
            return mk(p == 0, p == 1 || p == 2, p == 3 || p == 4,
                      !md && (p == 5 || p == 6), !md && (p == 7 || p == 8),
                      1'b1, 1'b0, ((k - 1) / s) % 4, (k - 1) / (4 * s));
        end else if (k == done_cyc) begin
            return mk(0, 0, 0, 0, 0, 1'b1, 1'b1, 0, final_ep);
        end
        return mk(0, 0, 0, 0, 0, 1'b0, 1'b0, 0, final_ep);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    typedef struct {
        logic       md;
        logic [7:0] ep;
        int         done_cyc;
        int         n_ld;
        int         final_ep;
    } vec_t;

    vec_t vecs[6];

    task automatic launch(input logic md, input logic [7:0] ep);
        @(negedge clk);
        mode   = md;
        epochs = ep;
        start  = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nld = 0;
        launch(v.md, v.ep);
        for (int k = 1; k <= v.done_cyc + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("vec%0d cyc%0d", idx, k), 32'(pack_out()),
                  32'(exp_out(v.md, k, v.done_cyc, v.final_ep)));
            if (ld) nld++;
            // Mid-run changes to mode/epochs and a stray start must not matter.
            if (k == 2) begin
                mode   = ~v.md;
                epochs = 8'hA5;
            end
            if (k == 7 && k < v.done_cyc - 1) start = 1'b1;
        end
        check($sformatf("vec%0d ld count", idx), 32'(nld), 32'(v.n_ld));
        check($sformatf("vec%0d final epoch", idx), 32'(epoch_cnt), 32'(v.final_ep));
        mode   = 1'b0;
        epochs = 8'd1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'd1, 41, 4, 1};
        vecs[1] = '{1'b1, 8'd5, 25, 4, 1};
        vecs[2] = '{1'b0, 8'd3, 121, 12, 3};
        vecs[3] = '{1'b0, 8'd0, 1, 0, 0};
        vecs[4] = '{1'b1, 8'd0, 25, 4, 1};
        vecs[5] = '{1'b0, 8'd2, 81, 8, 2};

        rst = 1'b1; start = 1'b0; mode = 1'b0; epochs = 8'd1; abort = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outputs", 32'(pack_out()), 32'(19'h0));
        rst = 1'b0;
        @(negedge clk);
        check("idle after reset", 32'(pack_out()), 32'(19'h0));

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Abort during the second BPO cycle of sample 2.
        launch(1'b0, 8'd1);
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre-abort BPO", 32'(pack_out()), 32'(mk(0, 0, 0, 1, 0, 1, 0, 2, 0)));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort -> idle", 32'(pack_out()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 2, 0)));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort hold %0d", k), 32'(pack_out()),
                  32'(mk(0, 0, 0, 0, 0, 0, 0, 2, 0)));
        end
        launch(1'b0, 8'd1);
        @(negedge clk);
        start = 1'b0;
        check("restart addr 0", 32'(pack_out()), 32'(mk(1, 0, 0, 0, 0, 1, 0, 0, 0)));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort after ld", 32'(pack_out()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)));

        // abort alone in IDLE does nothing; abort with start blocks the start.
        abort = 1'b1;
        @(negedge clk);
        check("abort in idle", 32'(pack_out()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort beats start", 32'(pack_out()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        check("abort beats start +1", 32'(busy), 32'(1'b0));

        // Async reset during P_FPO of sample 1.
        launch(1'b0, 8'd1);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre-reset FPO", 32'(pack_out()), 32'(mk(0, 0, 1, 0, 0, 1, 0, 1, 0)));
        rst = 1'b1;
        #1;
        check("async reset clears", 32'(pack_out()), 32'(19'h0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post-reset idle %0d", k), 32'(pack_out()), 32'(19'h0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/train_sequencer.md
Name: train_sequencer

Overview:
- Top-level scheduler for the Q8.8 (16-bit) two-layer network.
- Steps the hidden-layer and output-layer neurons through their phases for every sample in the training set: load, forward hidden, forward output, backprop output, backprop hidden.
- Drives the neurons' phase strobes and the sample-memory address, and counts samples and epochs.
- Validation mode runs one forward-only pass over all samples.

Parameters:
NSAMP, 4, samples per epoch (>=1)
AW, 2, sample address width, 2^AW >= NSAMP
EPW, 8, epoch counter width
FPH_CYC, 2, cycles FPH is held (>=1)
FPO_CYC, 2, cycles FPO is held (>=1)
BPO_CYC, 2, cycles BPO is held (>=1)
BPH_CYC, 2, cycles BPH is held (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  launch a run, sampled in IDLE only
mode  in  1  0 = train, 1 = validate; latched at start
epochs  in  EPW  epoch count for a train run; latched at start
abort  in  1  synchronous cancel of the current run
ld  out  1  one-cycle sample-load strobe to sample memory and x registers
addr  out  AW  sample index being processed
FPH  out  1  forward-pass strobe, hidden layer
FPO  out  1  forward-pass strobe, output layer
BPO  out  1  backprop strobe, output layer
BPH  out  1  backprop strobe, hidden layer
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a run completes
epoch_cnt  out  EPW  epochs completed in the current run
sample_cnt  out  AW  equals addr

Behaviour:
- Reset (async, rst=1): state IDLE; every output 0; all counters 0.
- All outputs are registered. ld, FPH, FPO, BPO and BPH are mutually exclusive.
- States: IDLE, LOAD, P_FPH, P_FPO, P_BPO, P_BPH, NEXT, DONE.
- IDLE:
  - On start=1: latch mode and epochs; clear addr and epoch_cnt.
  - Next state is DONE if mode=0 and epochs=0; otherwise LOAD.
- LOAD: ld=1 for exactly 1 cycle, addr valid. Next state P_FPH.
- P_FPH, P_FPO, P_BPO, P_BPH:
  - Each holds its strobe for its *_CYC cycles, using a phase down-counter reloaded on entry.
  - Order is FPH -> FPO -> BPO -> BPH, so output dZ exists before hidden backprop.
  - In validate mode, P_FPO goes directly to NEXT; BPO and BPH never assert.
- NEXT (1 cycle, no strobes):
  - If addr = NSAMP-1: addr wraps to 0 and epoch_cnt increments.
    - Validate mode: go to DONE.
    - Train mode: go to DONE if the incremented epoch_cnt equals the latched epochs; otherwise go to LOAD.
  - Otherwise: addr increments; go to LOAD.
- DONE: done=1 for 1 cycle, busy=1. Next state IDLE. epoch_cnt and addr hold their final values until the next start.
- Latency from start sampled to the first ld: 1 cycle.
- Cycles per sample:
  - Train: 2 + FPH_CYC + FPO_CYC + BPO_CYC + BPH_CYC.
  - Validate: 2 + FPH_CYC + FPO_CYC.
- start while busy: ignored. Changes to mode or epochs mid-run: no effect.
- abort=1 in any non-IDLE state:
  - Next cycle is IDLE with all strobes 0 and done not asserted.
  - Counters hold their values.
- abort has priority over every other transition. abort in IDLE: no effect. abort and start together in IDLE: abort wins and the run does not start.
- epoch_cnt does not wrap within a run; epochs max is 2^EPW-1.
- rst asserted mid-run: immediate return to IDLE; outputs cleared; no done.

Test Plan:
1. Reset, then start=1 with mode=0, epochs=1 (defaults) -> ld at cycles 1, 11, 21, 31 with addr 0..3. Strobe order per sample: ld, FPH x2, FPO x2, BPO x2, BPH x2, gap. done pulses at cycle 41; busy high for cycles 1-41; epoch_cnt=1 afterwards.
2. mode=1, epochs=5 -> 4 samples at 6 cycles each; BPO and BPH never assert; done at cycle 25; epoch_cnt=1.
3. mode=0, epochs=3 -> 12 ld pulses with addr sequence 0,1,2,3 repeated three times. epoch_cnt steps to 1, 2, 3 on the NEXT cycles following addr=3. done at cycle 121.
4. mode=0, epochs=0 -> no ld and no strobes; done at cycle 1; busy high for exactly 1 cycle.
5. abort during the second BPO cycle of sample 2 -> next cycle IDLE with strobes 0 and no done; addr=2 holds. A new start then reloads addr=0.
6. start pulsed again mid-run, and rst asserted during P_FPO -> the extra start has no effect on the sequence. rst clears all outputs asynchronously.
